ic_dest_rx_fifo: RTL and testbench

- Destination-side receive buffer sitting directly downstream of the interconnect destination partition stage 3 output.
- Accepts one flit per cycle with its 7-bit nexthop (4-bit local node ID, 3-bit port ID) and acknowledges it on `dequeue` in the same cycle, so the upstream stage never flags an unacknowledged-data error.
- Buffers flits in a small FIFO and presents them to the node input logic through a valid/ready handshake.
- Raises a sticky error on overflow or on a node-ID mismatch.

---
 rtl/ic_dest_rx_fifo.sv | 93 +++++++++
 tb/tb_ic_dest_rx_fifo.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ic_dest_rx_fifo.sv
// Destination receive FIFO: same-cycle combinational ack (dequeue) to stage 3, first-word-fall-through head with 1-cycle push-to-visible latency.
// Backpressure: a full FIFO withholds dequeue unless the head pops that cycle; overflow and node-ID mismatch set a sticky error.
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 32
`endif

module ic_dest_rx_fifo #(
  parameter int         WIDTH   = `FLIT_WIDTH,
  parameter int         DEPTH   = 4,
  parameter logic [3:0] NODE_ID = 4'b0000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  output logic                   error,
  input  logic [WIDTH-1:0]       s3_data_in,
  input  logic [6:0]             s3_nexthop_in,
  input  logic                   s3_data_valid,
  output logic                   dequeue,
  output logic [WIDTH-1:0]       out_data,
  output logic [2:0]             out_port,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   almost_full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = WIDTH + 3;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          error_q, error_d;
  logic [EW-1:0] mem_q [DEPTH];

  logic          full, pop, push, node_ok, overflow;
  logic [EW-1:0] head;

  always_comb begin
    full     = (count_q == CW'(DEPTH));
    pop      = enable & (count_q != '0) & out_ready;
    // Gated by reset so nothing is acknowledged while state is being cleared.
    dequeue  = reset & enable & s3_data_valid & (~full | pop);
    node_ok  = (s3_nexthop_in[6:3] == NODE_ID);
    push     = dequeue & node_ok;
    overflow = enable & s3_data_valid & full & ~pop;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    error_d  = error_q | overflow | (dequeue & ~node_ok);
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      error_q  <= error_d;
    end
  end

  // Storage needs no reset; the head is masked to zero while empty.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= {s3_data_in, s3_nexthop_in[2:0]};
  end

  always_comb begin
    head        = mem_q[rd_ptr_q];
    out_valid   = (count_q != '0);
    out_data    = out_valid ? head[EW-1:3] : '0;
    out_port    = out_valid ? head[2:0] : 3'd0;
    count       = count_q;
    almost_full = (count_q >= CW'(DEPTH - 1));
    error       = error_q;
  end

endmodule

// File: tb/tb_ic_dest_rx_fifo.sv
// Bench for ic_dest_rx_fifo: directed vector table, corner sequences, then random traffic against a queue model.
module tb_ic_dest_rx_fifo;
  localparam int         W    = 16;
  localparam int         D    = 4;
  localparam logic [3:0] NODE = 4'h5;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic          error;
  logic [W-1:0]  s3_data_in;
  logic [6:0]    s3_nexthop_in;
  logic          s3_data_valid;
  logic          dequeue;
  logic [W-1:0]  out_data;
  logic [2:0]    out_port;
  logic          out_valid;
  logic          out_ready;
  logic [2:0]    count;
  logic          almost_full;

  int n_vec = 0;
  int n_bad = 0;

  ic_dest_rx_fifo #(.WIDTH(W), .DEPTH(D), .NODE_ID(NODE)) dut (
    .clock(clock), .reset(reset), .enable(enable), .error(error),
    .s3_data_in(s3_data_in), .s3_nexthop_in(s3_nexthop_in), .s3_data_valid(s3_data_valid),
    .dequeue(dequeue), .out_data(out_data), .out_port(out_port), .out_valid(out_valid),
    .out_ready(out_ready), .count(count), .almost_full(almost_full)
  );

  always #5 clock = ~clock;

  // Reference model: an ordered queue of {data, port} plus a sticky error bit.
  logic [W+2:0] q[$];
  bit           m_err;
  bit           e_pop, e_deq, e_full, e_match;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic en, input logic vld, input logic [W-1:0] d,
                       input logic [6:0] nh, input logic rdy);
    enable        = en;
    s3_data_valid = vld;
    s3_data_in    = d;
    s3_nexthop_in = nh;
    out_ready     = rdy;
  endtask

  task automatic model_check();
    logic [W+2:0] hd;
    e_full  = (q.size() == D);
    e_pop   = enable && (q.size() != 0) && out_ready;
    e_deq   = enable && s3_data_valid && (!e_full || e_pop);
    e_match = (s3_nexthop_in[6:3] == NODE);
    hd      = (q.size() != 0) ? q[0] : '0;
    chk("m_dequeue", dequeue, e_deq);
    chk("m_out_valid", out_valid, q.size() != 0);
    chk("m_count", count, q.size());
    chk("m_almost_full", almost_full, q.size() >= D - 1);
    chk("m_error", error, m_err);
    chk("m_out_data", out_data, hd[W+2:3]);
    chk("m_out_port", out_port, hd[2:0]);
  endtask

  task automatic model_update();
    if (e_pop) void'(q.pop_front());
    if (e_deq && e_match) q.push_back({s3_data_in, s3_nexthop_in[2:0]});
    if ((e_deq && !e_match) || (enable && s3_data_valid && e_full && !e_pop)) m_err = 1'b1;
  endtask

  task automatic step(input logic en, input logic vld, input logic [W-1:0] d,
                      input logic [6:0] nh, input logic rdy);
    drive(en, vld, d, nh, rdy);
    @(negedge clock);
    model_check();
    @(posedge clock); #1;
    model_update();
  endtask

  // Entered at posedge+1; asserts reset mid-cycle with a valid flit offered.
  task automatic reset_dut();
    drive(1'b1, 1'b1, 16'h1234, {NODE, 3'd1}, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("rst_dequeue", dequeue, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_error", error, 0);
    q.delete();
    m_err = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    s3_data_valid = 1'b0;
  endtask

  typedef struct {
    logic en, vld; logic [W-1:0] d; logic [6:0] nh; logic rdy;
    logic deq, ov; logic [2:0] cnt; logic af, err; logic [W-1:0] od; logic [2:0] op;
  } vec_t;
  vec_t tbl[14];

  initial begin
    tbl[0]  = '{1, 0, 16'h0000, {NODE, 3'd0}, 0,  0, 0, 3'd0, 0, 0, 16'h0000, 3'd0};
    tbl[1]  = '{1, 1, 16'h00A5, {NODE, 3'd2}, 0,  1, 0, 3'd0, 0, 0, 16'h0000, 3'd0};
    tbl[2]  = '{1, 0, 16'h0000, {NODE, 3'd0}, 0,  0, 1, 3'd1, 0, 0, 16'h00A5, 3'd2};
    tbl[3]  = '{1, 1, 16'h00B1, {NODE, 3'd3}, 0,  1, 1, 3'd1, 0, 0, 16'h00A5, 3'd2};
    tbl[4]  = '{1, 1, 16'h00B2, {NODE, 3'd4}, 0,  1, 1, 3'd2, 0, 0, 16'h00A5, 3'd2};
    tbl[5]  = '{1, 1, 16'h00B3, {NODE, 3'd5}, 0,  1, 1, 3'd3, 1, 0, 16'h00A5, 3'd2};
    tbl[6]  = '{1, 1, 16'h00C0, {NODE, 3'd1}, 0,  0, 1, 3'd4, 1, 0, 16'h00A5, 3'd2};
    tbl[7]  = '{1, 1, 16'h00C1, {NODE, 3'd6}, 1,  1, 1, 3'd4, 1, 1, 16'h00A5, 3'd2};
    tbl[8]  = '{1, 0, 16'h0000, {NODE, 3'd0}, 0,  0, 1, 3'd4, 1, 1, 16'h00B1, 3'd3};
    tbl[9]  = '{1, 0, 16'h0000, {NODE, 3'd0}, 1,  0, 1, 3'd4, 1, 1, 16'h00B1, 3'd3};
    tbl[10] = '{1, 0, 16'h0000, {NODE, 3'd0}, 1,  0, 1, 3'd3, 1, 1, 16'h00B2, 3'd4};
    tbl[11] = '{1, 0, 16'h0000, {NODE, 3'd0}, 1,  0, 1, 3'd2, 0, 1, 16'h00B3, 3'd5};
    tbl[12] = '{1, 0, 16'h0000, {NODE, 3'd0}, 1,  0, 1, 3'd1, 0, 1, 16'h00C1, 3'd6};
    tbl[13] = '{1, 0, 16'h0000, {NODE, 3'd0}, 0,  0, 0, 3'd0, 0, 1, 16'h0000, 3'd0};

    reset = 1'b0;
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    m_err = 1'b0;
    #12 reset = 1'b1;
    @(posedge clock); #1;

    // Directed table: first flit, fill, overflow, full push+pop, drain.
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].en, tbl[i].vld, tbl[i].d, tbl[i].nh, tbl[i].rdy);
      @(negedge clock);
      model_check();
      chk($sformatf("t%0d_dequeue", i), dequeue, tbl[i].deq);
      chk($sformatf("t%0d_out_valid", i), out_valid, tbl[i].ov);
      chk($sformatf("t%0d_count", i), count, tbl[i].cnt);
      chk($sformatf("t%0d_almost_full", i), almost_full, tbl[i].af);
      chk($sformatf("t%0d_error", i), error, tbl[i].err);
      chk($sformatf("t%0d_out_data", i), out_data, tbl[i].od);
      chk($sformatf("t%0d_out_port", i), out_port, tbl[i].op);
      @(posedge clock); #1;
      model_update();
    end

    // Streaming: 10 flits through with the consumer always ready.
    reset_dut();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 16'h0100 + 16'(i), {NODE, 3'(i)}, 1'b1);
      @(negedge clock);
      model_check();
      chk("stream_count_le1", count <= 3'd1, 1);
      @(posedge clock); #1;
      model_update();
    end
    drive(1'b1, 1'b0, '0, {NODE, 3'd0}, 1'b1);
    @(negedge clock);
    model_check();
    chk("stream_last_data", out_data, 16'h0109);
    chk("stream_last_port", out_port, 3'd1);
    chk("stream_error", error, 0);
    @(posedge clock); #1;
    model_update();
    step(1'b1, 1'b0, '0, {NODE, 3'd0}, 1'b0);

    // Node-ID mismatch: acknowledged, discarded, error set.
    reset_dut();
    drive(1'b1, 1'b1, 16'hDEAD, {NODE ^ 4'h1, 3'd1}, 1'b0);
    @(negedge clock);
    model_check();
    chk("mm_dequeue", dequeue, 1);
    @(posedge clock); #1;
    model_update();
    drive(1'b1, 1'b0, '0, {NODE, 3'd0}, 1'b0);
    @(negedge clock);
    model_check();
    chk("mm_count", count, 0);
    chk("mm_out_valid", out_valid, 0);
    chk("mm_error", error, 1);
    @(posedge clock); #1;
    model_update();

    // Enable low holds everything, then asynchronous reset mid-cycle.
    step(1'b1, 1'b1, 16'h0077, {NODE, 3'd7}, 1'b0);
    drive(1'b0, 1'b1, 16'h0088, {NODE, 3'd1}, 1'b1);
    @(negedge clock);
    model_check();
    chk("en0_dequeue", dequeue, 0);
    chk("en0_count", count, 1);
    chk("en0_head", out_data, 16'h0077);
    @(posedge clock); #1;
    model_update();
    @(negedge clock);
    model_check();
    chk("en0_count_hold", count, 1);
    chk("en0_error_hold", error, 1);
    #1 reset = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_count", count, 0);
    chk("arst_error", error, 0);
    chk("arst_dequeue", dequeue, 0);
    q.delete();
    m_err = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;

    // Random traffic against the queue model, with periodic resets.
    for (int i = 0; i < 600; i++) begin
      if (i % 100 == 99) begin
        reset_dut();
      end else begin
        step(($urandom_range(0, 9) != 0),
             ($urandom_range(0, 2) != 0),
             W'($urandom),
             {(($urandom_range(0, 19) != 0) ? NODE : 4'($urandom_range(0, 15))), 3'($urandom_range(0, 7))},
             ($urandom_range(0, 2) != 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
